// File: rtl/cs_symbol_packer.sv
// Ingress framer: groups payload words into M-symbol generations, lifting each word
// to an even-parity symbol, with two ping-pong banks between the input and output sides.
module cs_symbol_packer #(
  parameter int M        = 3,
  parameter int WIDTH    = 11,
  parameter int DATA_W   = WIDTH - 1,
  parameter int GEN_ID_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_W-1:0]        in_data,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [M*WIDTH-1:0]       decoded_symbols_flat,
  output logic [$clog2(M+1)-1:0]   out_count,
  output logic [GEN_ID_W-1:0]      out_gen_id
);

  localparam int CNT_W  = $clog2(M + 1);
  localparam int SLOT_W = (M > 1) ? $clog2(M) : 1;

  logic                    wr_bank_q, wr_bank_d;
  logic                    rd_bank_q, rd_bank_d;
  logic [SLOT_W-1:0]       wr_slot_q, wr_slot_d;
  logic [GEN_ID_W-1:0]     gen_cnt_q, gen_cnt_d;

  logic [1:0]                    full_vec;
  logic [1:0][M*WIDTH-1:0]       bank_flat;
  logic [1:0][CNT_W-1:0]         bank_count;
  logic [1:0][GEN_ID_W-1:0]      bank_gen_id;

  logic              accept;
  logic              seal;
  logic              drain;
  logic              last_slot;
  logic [WIDTH-1:0]  lift_sym;

  assign lift_sym  = {^in_data, in_data};
  assign last_slot = (wr_slot_q == SLOT_W'(M - 1));

  assign in_ready  = !full_vec[wr_bank_q] && !rst;
  assign accept    = in_valid && in_ready;
  assign seal      = accept && (last_slot || in_last);

  assign out_valid            = full_vec[rd_bank_q];
  assign drain                = out_valid && out_ready;
  assign decoded_symbols_flat = bank_flat[rd_bank_q];
  assign out_count            = bank_count[rd_bank_q];
  assign out_gen_id           = bank_gen_id[rd_bank_q];

  always_comb begin
    wr_bank_d = wr_bank_q ^ seal;
    rd_bank_d = rd_bank_q ^ drain;
    gen_cnt_d = gen_cnt_q + GEN_ID_W'(seal);
    wr_slot_d = wr_slot_q;
    if (seal) begin
      wr_slot_d = '0;
    end else if (accept) begin
      wr_slot_d = wr_slot_q + SLOT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      wr_slot_q <= '0;
      gen_cnt_q <= '0;
    end else begin
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      wr_slot_q <= wr_slot_d;
      gen_cnt_q <= gen_cnt_d;
    end
  end

  genvar gb, gs;
  generate
    for (gb = 0; gb < 2; gb++) begin : g_bank
      logic                wr_here;
      logic                seal_here;
      logic                drain_here;
      logic                full_q, full_d;
      logic [CNT_W-1:0]    count_q, count_d;
      logic [GEN_ID_W-1:0] gen_id_q, gen_id_d;

      assign wr_here    = accept && (wr_bank_q == 1'(gb));
      assign seal_here  = seal && (wr_bank_q == 1'(gb));
      assign drain_here = drain && (rd_bank_q == 1'(gb));

      // Seal and drain never hit the same bank: sealing needs it empty, draining needs it full.
      always_comb begin
        full_d   = full_q;
        count_d  = count_q;
        gen_id_d = gen_id_q;
        if (drain_here) begin
          full_d = 1'b0;
        end
        if (seal_here) begin
          full_d   = 1'b1;
          count_d  = CNT_W'(wr_slot_q) + CNT_W'(1);
          gen_id_d = gen_cnt_q;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          full_q   <= 1'b0;
          count_q  <= '0;
          gen_id_q <= '0;
        end else begin
          full_q   <= full_d;
          count_q  <= count_d;
          gen_id_q <= gen_id_d;
        end
      end

      assign full_vec[gb]    = full_q;
      assign bank_count[gb]  = count_q;
      assign bank_gen_id[gb] = gen_id_q;

      for (gs = 0; gs < M; gs++) begin : g_slot
        logic [WIDTH-1:0] sym_q, sym_d;

        // Slots beyond the sealing word are cleared so short generations read as zero-padded.
        always_comb begin
          sym_d = sym_q;
          if (wr_here) begin
            if (wr_slot_q == SLOT_W'(gs)) begin
              sym_d = lift_sym;
            end else if (seal && (SLOT_W'(gs) > wr_slot_q)) begin
              sym_d = '0;
            end
          end
        end

        always_ff @(posedge clk) begin
          if (rst) begin
            sym_q <= '0;
          end else begin
            sym_q <= sym_d;
          end
        end

        assign bank_flat[gb][gs*WIDTH +: WIDTH] = sym_q;
      end
    end
  endgenerate

endmodule

// File: tb/tb_cs_symbol_packer.sv
// Randomized and directed bench for cs_symbol_packer, scored against a queue-based
// model of generations (lift, zero padding, gen-id sequence, two-deep buffering).
module tb_cs_symbol_packer;
  localparam int M        = 3;
  localparam int WIDTH    = 11;
  localparam int DATA_W   = 10;
  localparam int GEN_ID_W = 8;
  localparam int CNT_W    = $clog2(M + 1);

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 in_valid = 1'b0;
  logic                 in_last = 1'b0;
  logic                 out_ready = 1'b0;
  logic [DATA_W-1:0]    in_data = '0;
  logic                 in_ready;
  logic                 out_valid;
  logic [M*WIDTH-1:0]   flat;
  logic [CNT_W-1:0]     out_count;
  logic [GEN_ID_W-1:0]  out_gen_id;

  cs_symbol_packer #(
    .M(M), .WIDTH(WIDTH), .DATA_W(DATA_W), .GEN_ID_W(GEN_ID_W)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .decoded_symbols_flat(flat), .out_count(out_count), .out_gen_id(out_gen_id)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [M*WIDTH-1:0] flat;
    int                 cnt;
    int                 gid;
  } gen_t;

  gen_t              pend[$];
  logic [DATA_W-1:0] bld[$];
  int                gid_ctr = 0;
  int                n_chk = 0;
  int                n_bad = 0;
  bit                acc_last = 0;
  int                rel_total = 0;
  int                last_rel_gid = -1;
  bit                saw_wrap = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, act, exp);
    end
  endtask

  // Close the words collected so far into one expected generation.
  task automatic model_seal();
    gen_t g;
    logic [DATA_W-1:0] w;
    g.flat = '0;
    for (int r = 0; r < bld.size(); r++) begin
      w = bld[r];
      g.flat[r*WIDTH +: WIDTH] = {^w, w};
    end
    g.cnt   = bld.size();
    g.gid   = gid_ctr;
    gid_ctr = (gid_ctr + 1) % 256;
    pend.push_back(g);
    bld.delete();
  endtask

  task automatic cycle();
    bit acc, rel;
    logic [GEN_ID_W-1:0] obs_gid;
    @(negedge clk);
    obs_gid = out_gen_id;
    if (rst) begin
      chk("ready_in_rst", in_ready, 0);
    end else begin
      chk("in_ready", in_ready, pend.size() < 2);
      chk("out_valid", out_valid, pend.size() > 0);
      if (pend.size() > 0) begin
        chk("flat", flat, pend[0].flat);
        chk("count", out_count, pend[0].cnt);
        chk("gen_id", out_gen_id, pend[0].gid);
      end
    end
    acc = !rst && in_valid && (pend.size() < 2);
    rel = !rst && out_ready && (pend.size() > 0);
    @(posedge clk);
    if (rst) begin
      pend.delete();
      bld.delete();
      gid_ctr = 0;
    end else begin
      if (rel) begin
        $display("gen out: id=%0d count=%0d flat=%0h", pend[0].gid, pend[0].cnt, pend[0].flat);
        if (last_rel_gid == 255 && obs_gid == 0) saw_wrap = 1;
        last_rel_gid = obs_gid;
        rel_total++;
        void'(pend.pop_front());
      end
      if (acc) begin
        bld.push_back(in_data);
        if (in_last || bld.size() == M) model_seal();
      end
    end
    acc_last = acc;
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    in_last  = 1'b0;
    repeat (n) cycle();
  endtask

  task automatic send(input logic [DATA_W-1:0] d, input bit last);
    int t;
    t = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    do begin
      cycle();
      t++;
    end while (!acc_last && t < 50);
    chk("send_accept", acc_last, 1);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    cycle();
    cycle();
    chk("rst_valid", out_valid, 0);
    chk("rst_flat", flat, 0);
    chk("rst_count", out_count, 0);
    chk("rst_gid", out_gen_id, 0);
    chk("rst_ready", in_ready, 0);
    rst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [M*WIDTH-1:0] exp_flat;
    int n, cyc, rel0;

    // Basic generation
    do_reset();
    out_ready = 1'b1;
    send(10'h001, 0);
    send(10'h003, 0);
    send(10'h3FF, 0);
    exp_flat = {11'h3FF, 11'h003, 11'h401};
    chk("basic_valid", out_valid, 1);
    chk("basic_flat", flat, exp_flat);
    chk("basic_count", out_count, 3);
    chk("basic_gid", out_gen_id, 0);
    idle(2);

    // Early close, then a full generation
    do_reset();
    out_ready = 1'b1;
    send(10'h007, 1);
    exp_flat = {11'h000, 11'h000, 11'h407};
    chk("early_flat", flat, exp_flat);
    chk("early_count", out_count, 1);
    chk("early_gid", out_gen_id, 0);
    idle(1);
    for (int i = 0; i < 3; i++) send(DATA_W'($urandom), 0);
    chk("early_next_gid", out_gen_id, 1);
    chk("early_next_count", out_count, 3);
    idle(2);

    // Back-pressure: both banks fill, then one release reopens the input
    do_reset();
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_data = DATA_W'(16 + k);
      cycle();
    end
    chk("bp_ready_low", in_ready, 0);
    in_data = DATA_W'(99);
    repeat (4) cycle();
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    chk("bp_ready_back", in_ready, 1);
    cycle();
    chk("bp_7th_accept", acc_last, 1);
    chk("bp_gen1_gid", out_gen_id, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    idle(3);

    // Reset with a sealed bank pending and a partial generation
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(DATA_W'($urandom), 0);
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) send(DATA_W'($urandom), 0);
    chk("post_rst_gid", out_gen_id, 0);
    chk("post_rst_count", out_count, 3);
    idle(2);

    // Sustained streaming, three rounds so the gen-id counter wraps
    out_ready = 1'b1;
    for (int round = 0; round < 3; round++) begin
      rel0 = rel_total;
      n = 0;
      cyc = 0;
      in_valid = 1'b1;
      in_last  = 1'b0;
      while (n < 300 && cyc < 1000) begin
        in_data = DATA_W'($urandom);
        cycle();
        cyc++;
        if (acc_last) n++;
      end
      in_valid = 1'b0;
      chk("stream_cycles", cyc, 300);
      idle(3);
      chk("stream_gens", rel_total - rel0, 100);
    end
    chk("gid_wrap", saw_wrap, 1);

    // Random handshake
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = DATA_W'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      cycle();
    end
    out_ready = 1'b1;
    idle(4);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
